// File: rtl/fp_mant_div.sv
// fp_mant_div: sequential radix-2 restoring divider for normalized FP mantissas.
// Produces one quotient bit per cycle. The result has QW bits: 1 integer bit and
// QW-1 fraction bits. It also reports a sticky bit (remainder nonzero) and a
// normalization flag, so normalize/pack can round without a wide divider.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start        one-cycle request; operands sampled on the same edge (ignored while busy)
//   dividend_m   dividend mantissa A (hidden bit included)
//   divisor_m    divisor mantissa B (hidden bit included)
//   busy         iteration in progress
//   done         one-cycle completion pulse; result outputs valid from this cycle
//   quotient     floor(A * 2^(QW-1) / B)
//   sticky       remainder nonzero
//   norm         quotient MSB (1: result in [1,2), 0: result in [0.5,1))
//   dbz          divisor was zero
module fp_mant_div #(
  parameter  int MANT_W = 24,
  localparam int QW     = MANT_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] dividend_m,
  input  logic [MANT_W-1:0] divisor_m,
  output logic              busy,
  output logic              done,
  output logic [QW-1:0]     quotient,
  output logic              sticky,
  output logic              norm,
  output logic              dbz
);

  localparam int RW    = MANT_W + 2;
  localparam int CNT_W = $clog2(QW);

  typedef enum logic [0:0] {IDLE, CALC} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Datapath registers carry no reset; they are always loaded before use.
  logic [RW-1:0]      rem;
  logic [MANT_W-1:0]  div_b;
  logic [QW-1:0]      q_sr;
  logic               a_nz;
  logic               dbz_pend;

  logic               q_bit;
  logic [RW-1:0]      rem_sub;
  logic [QW-1:0]      q_next;

  // One restoring step: compare against the zero-extended divisor.
  function automatic logic [RW:0] div_step(input logic [RW-1:0] r, input logic [MANT_W-1:0] b);
    logic [RW-1:0] bx;
    bx = {2'b00, b};
    if (r >= bx) div_step = {1'b1, r - bx};
    else         div_step = {1'b0, r};
  endfunction

  always_comb begin
    {q_bit, rem_sub} = div_step(rem, div_b);
    q_next           = {q_sr[QW-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      div_b    <= divisor_m;
      rem      <= {2'b00, dividend_m};
      q_sr     <= '0;
      a_nz     <= |dividend_m;
      dbz_pend <= (divisor_m == '0);
    end else if (state == CALC) begin
      rem  <= rem_sub << 1;
      q_sr <= q_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      sticky   <= 1'b0;
      norm     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= CNT_W'(QW - 1);
          end
        end
        CALC: begin
          if (cnt == '0) begin
            // Divide by zero still runs the full iteration count; its result
            // is forced to saturate and sticky reflects a nonzero dividend.
            quotient <= dbz_pend ? '1 : q_next;
            sticky   <= dbz_pend ? a_nz : (rem_sub != '0);
            norm     <= dbz_pend ? 1'b1 : q_next[QW-1];
            dbz      <= dbz_pend;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mant_div.sv
// Self-checking bench for fp_mant_div: directed cases with literal expectations,
// randomized operations checked against a plain-arithmetic reference model, and
// a per-cycle monitor of busy/done timing and result values.
module tb_fp_mant_div;

  localparam int MANT_W = 24;
  localparam int QW     = MANT_W + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [MANT_W-1:0] dividend_m;
  logic [MANT_W-1:0] divisor_m;
  logic              busy;
  logic              done;
  logic [QW-1:0]     quotient;
  logic              sticky;
  logic              norm;
  logic              dbz;

  fp_mant_div #(.MANT_W(MANT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend_m(dividend_m), .divisor_m(divisor_m),
    .busy(busy), .done(done), .quotient(quotient),
    .sticky(sticky), .norm(norm), .dbz(dbz)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [MANT_W-1:0] a;
    logic [MANT_W-1:0] b;
    int                c0;
  } op_t;

  op_t sb[$];

  // Reference: exact floor division of A * 2^(QW-1) by B.
  function automatic void model(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                                output logic [QW-1:0] qq, output logic s,
                                output logic n, output logic z);
    longint unsigned num;
    longint unsigned quo;
    if (b == 0) begin
      qq = '1;
      s  = (a != 0);
      n  = 1'b1;
      z  = 1'b1;
    end else begin
      num = longint'(a) << (QW - 1);
      quo = num / longint'(b);
      qq  = quo[QW-1:0];
      s   = (num % longint'(b)) != 0;
      n   = qq[QW-1];
      z   = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: timing of busy/done and result values at done.
  int          m_d;
  logic [QW-1:0] m_q;
  logic        m_s, m_n, m_z;
  always @(negedge clk) begin
    if (!rst) begin
      m_d = (sb.size() > 0) ? (cyc - sb[0].c0) : -1;
      chk("busy", busy, (m_d >= 0 && m_d <= QW - 1));
      chk("done", done, (m_d == QW));
      if (m_d == QW && done) begin
        model(sb[0].a, sb[0].b, m_q, m_s, m_n, m_z);
        chk("quotient", quotient, m_q);
        chk("sticky", sticky, m_s);
        chk("norm", norm, m_n);
        chk("dbz", dbz, m_z);
      end
      if (m_d >= QW) void'(sb.pop_front());
    end
  end

  // Issue a start; if now=1 the caller is already at a negedge (e.g. done cycle).
  task automatic launch(input bit now, input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b);
    op_t o;
    if (!now) @(negedge clk);
    #1;
    start      = 1'b1;
    dividend_m = a;
    divisor_m  = b;
    o.a = a; o.b = b; o.c0 = cyc + 1;
    sb.push_back(o);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < QW + 5; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 required=1 (t=%0t)", $time);
    end
  endtask

  task automatic run_dir(input string name, input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                         input logic [QW-1:0] eq, input logic es, input logic en, input logic ez);
    bit seen;
    launch(1'b0, a, b);
    wait_done(seen);
    chk({name, "_q"}, quotient, eq);
    chk({name, "_s"}, sticky, es);
    chk({name, "_n"}, norm, en);
    chk({name, "_z"}, dbz, ez);
  endtask

  initial begin
    bit seen;
    logic [MANT_W-1:0] ra, rb;
    rst        = 1'b1;
    start      = 1'b0;
    dividend_m = '0;
    divisor_m  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_s", sticky, 0);
    chk("rst_n", norm, 0);
    chk("rst_z", dbz, 0);
    #1 rst = 1'b0;

    // Directed cases with hand-computed results.
    run_dir("one_one",  24'h800000, 24'h800000, 27'h4000000, 1'b0, 1'b1, 1'b0);
    run_dir("one_1p5",  24'h800000, 24'hC00000, 27'h2AAAAAA, 1'b1, 1'b0, 1'b0);
    run_dir("max_one",  24'hFFFFFF, 24'h800000, 27'h7FFFFF8, 1'b0, 1'b1, 1'b0);
    run_dir("dbz",      24'hC00000, 24'h000000, 27'h7FFFFFF, 1'b1, 1'b1, 1'b1);
    run_dir("zero_dbz", 24'h000000, 24'h000000, 27'h7FFFFFF, 1'b0, 1'b1, 1'b1);

    // Outputs hold after completion.
    repeat (3) @(negedge clk);
    chk("hold_q", quotient, 27'h7FFFFFF);
    chk("hold_z", dbz, 1);

    // Start while busy is ignored; then start in the done cycle is accepted.
    launch(1'b0, 24'h800000, 24'hC00000);
    repeat (4) @(negedge clk);
    #1;
    start      = 1'b1;
    dividend_m = 24'hFFFFFF;
    divisor_m  = 24'h000000;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(seen);
    chk("ign_q", quotient, 27'h2AAAAAA);
    chk("ign_z", dbz, 0);
    launch(1'b1, 24'hFFFFFF, 24'h800000);
    wait_done(seen);
    chk("b2b_q", quotient, 27'h7FFFFF8);

    // Reset mid-operation aborts immediately.
    launch(1'b0, 24'hC00000, 24'hC00000);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_s", sticky, 0);
    chk("abort_n", norm, 0);
    chk("abort_z", dbz, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (QW + 5) @(negedge clk);
    run_dir("after_rst", 24'hC00000, 24'h800000, 27'h6000000, 1'b0, 1'b1, 1'b0);

    // Randomized operations, some back-to-back from the done cycle.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      if ($urandom_range(0, 3) != 0) ra[MANT_W-1] = 1'b1;
      rb = $urandom();
      rb[MANT_W-1] = 1'b1;
      if ($urandom_range(0, 7) == 0) rb = '0;
      launch((i > 0) && ($urandom_range(0, 1) == 1) && done, ra, rb);
      wait_done(seen);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mant_div.md
# fp_mant_div

Sequential radix-2 restoring divider for normalized floating-point mantissas. It sits between operand unpacking and normalize/pack in the single-precision divide path. It returns a quotient with extra guard/round bits, a sticky bit and a normalization flag, so the downstream stage can renormalize and round without a wide combinational divide. Fixed latency, start/done handshake, one quotient bit per cycle.

## Interface
- MANT_W, 24, mantissa width including hidden bit
- QW, MANT_W+3, quotient width (1 integer bit + QW-1 fraction bits); derived, not overridden
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle request; operands sampled on the same edge
- dividend_m  input  MANT_W  dividend mantissa A, hidden bit included
- divisor_m  input  MANT_W  divisor mantissa B, hidden bit included
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  QW  floor(A * 2^(QW-1) / B)
- sticky  output  1  remainder nonzero
- norm  output  1  quotient[QW-1]; 1 means result in [1,2), 0 means [0.5,1)
- dbz  output  1  divisor_m was zero

## Operation
- States: IDLE, CALC.
- IDLE + start: capture B, remainder R <= {2'b0, A} (MANT_W+2 bits), clear quotient shift reg, load iteration counter with QW-1, latch dbz = (divisor_m == 0), go to CALC, busy=1.
- CALC, each cycle: if R >= B then q_bit=1, R' = R - B; else q_bit=0, R' = R. Quotient shifts left by one with q_bit in the LSB, and R <= R' << 1. The counter decrements.
- CALC with counter==0: perform the last iteration and write the output registers:
  - quotient <= final shift reg.
  - sticky <= (R' != 0).
  - norm <= quotient MSB.
  - dbz is latched.
  - done <= 1, busy <= 0, return to IDLE.
- dbz=1: quotient forced to all ones, sticky <= (A != 0), norm=1. Latency is unchanged.
- Results are defined for divisor_m[MANT_W-1]==1 or divisor_m==0. Other divisors give an unspecified quotient.
- A unnormalized (MSB 0) is legal; the quotient is the exact floor.
- Output registers hold their values until the next completion. They are not cleared by start.
- start while busy is ignored: no restart and no operand capture.
- The arithmetic width of R is MANT_W+2; the R >= B compare zero-extends B.

## Timing
- Reset values: busy=0, done=0, quotient=0, sticky=0, norm=0, dbz=0, state IDLE.
- The start edge is E0. busy is high from after E0 through the cycle before done.
- The last iteration is at edge E_QW (E27 for defaults). done is high for exactly the cycle following E_QW, concurrent with busy=0.
- Latency is QW cycles from the start edge to the done cycle, with a throughput of one operation per QW+1 cycles.
- start asserted in the done cycle is accepted (state is IDLE). The new operation's done comes QW cycles later.
- rst asserted mid-operation immediately returns all outputs to their reset values and aborts the operation. No done is produced.
- There is no combinational path from inputs to outputs.

## Test plan
- A=0x800000, B=0x800000 -> done after 27 cycles; quotient=0x4000000, sticky=0, norm=1, dbz=0.
- A=0x800000, B=0xC00000 (1.0/1.5) -> quotient=0x2AAAAAA, sticky=1, norm=0.
- A=0xFFFFFF, B=0x800000 -> quotient=0x7FFFFF8, sticky=0, norm=1.
- A=0xC00000, B=0 -> quotient=0x7FFFFFF, sticky=1, dbz=1, latency still 27.
- Pulse start again at cycle 5 with different operands -> ignored; the first result is unchanged and done comes at 27. Then pulse start in the done cycle -> the second done comes 27 cycles later with the correct result.
- Assert rst at cycle 10 of an operation -> busy/done/quotient/sticky/norm/dbz=0 immediately. No done pulse follows. A fresh start afterwards completes correctly (1.5/1.0 -> 0x6000000).
